// File: rtl/sort_pkg.sv
// Shared types and default constants for the sort engine frame controller.
// Macro SORT_TIMEOUT_EN (used by sort_frame_ctrl) enables the engine done timeout.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        KICK   = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } ctrl_state_t;

    localparam int SORT_N       = 6;
    localparam int SORT_WIDTH   = 8;
    localparam int SORT_TIMEOUT = 64;

endpackage

// File: rtl/sort_frame_buf.sv
// N x WIDTH register array: single-word write port, bulk parallel load and
// parallel read-out. Bulk load has priority over the word write.
module sort_frame_buf
    import sort_pkg::*;
#(
    parameter int N     = SORT_N,
    parameter int WIDTH = SORT_WIDTH,
    parameter int AW    = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    ld,
    input  logic [N-1:0][WIDTH-1:0] ld_data,
    output logic [N-1:0][WIDTH-1:0] q
);

    logic [N-1:0][WIDTH-1:0] mem_q;
    logic [N-1:0][WIDTH-1:0] mem_d;

    // Next contents of the array.
    always_comb begin
        mem_d = mem_q;
        if (ld) begin
            mem_d = ld_data;
        end else if (we) begin
            for (int k = 0; k < N; k++) begin
                if (waddr == AW'(k)) begin
                    mem_d[k] = wdata;
                end else begin
                    mem_d[k] = mem_q[k];
                end
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // Array storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign q = mem_q;

endmodule

// File: rtl/sort_frame_ctrl.sv
// Initiator-side frame controller for the array sort engine: load N words,
// pulse start, wait for done, stream the sorted frame out. Optional engine
// timeout is enabled by defining SORT_TIMEOUT_EN.
module sort_frame_ctrl
    import sort_pkg::*;
#(
    parameter int N       = SORT_N,
    parameter int WIDTH   = SORT_WIDTH,
    parameter int TIMEOUT = SORT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last,
    output logic                    srt_start,
    output logic [N-1:0][WIDTH-1:0] srt_data,
    input  logic                    srt_done,
    input  logic [N-1:0][WIDTH-1:0] srt_sorted,
    output logic                    busy,
    output logic                    err
);

    localparam int CW = $clog2(N + 1);

    ctrl_state_t             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic                    s_ready_q, s_ready_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [WIDTH-1:0]        m_data_q, m_data_d;
    logic                    srt_start_q, srt_start_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    frame_we_s;
    logic                    res_ld_s;
    logic [N-1:0][WIDTH-1:0] frame_s;
    logic [N-1:0][WIDTH-1:0] res_s;
    logic [CW-1:0]           idx_nxt_s;

`ifdef SORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
`endif

    assign idx_nxt_s = idx_q + CW'(1);

    sort_frame_buf #(.N(N), .WIDTH(WIDTH), .AW(CW)) u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (frame_we_s),
        .waddr   (cnt_q),
        .wdata   (s_data),
        .ld      (1'b0),
        .ld_data ('0),
        .q       (frame_s)
    );

    sort_frame_buf #(.N(N), .WIDTH(WIDTH), .AW(CW)) u_res_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (1'b0),
        .waddr   ('0),
        .wdata   ('0),
        .ld      (res_ld_s),
        .ld_data (srt_sorted),
        .q       (res_s)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        s_ready_d   = s_ready_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        srt_start_d = 1'b0;
        err_d       = 1'b0;
        frame_we_s  = 1'b0;
        res_ld_s    = 1'b0;
`ifdef SORT_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    frame_we_s = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d     = KICK;
                        s_ready_d   = 1'b0;
                        srt_start_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            KICK: begin
                state_d = WAIT;
`ifdef SORT_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            WAIT: begin
                if (srt_done) begin
                    res_ld_s  = 1'b1;
                    idx_d     = '0;
                    state_d   = UNLOAD;
                    m_valid_d = 1'b1;
                    // The result buffer loads on this edge, so word 0 comes straight from the engine.
                    m_data_d  = srt_sorted[0];
                    m_last_d  = 1'b0;
                end else begin
`ifdef SORT_TIMEOUT_EN
                    if (wait_q == TW'(TIMEOUT - 1)) begin
                        err_d     = 1'b1;
                        state_d   = LOAD;
                        cnt_d     = '0;
                        s_ready_d = 1'b1;
                    end else begin
                        wait_d  = wait_q + TW'(1);
                    end
`else
                    state_d = WAIT;
`endif
                end
            end
            UNLOAD: begin
                if (m_valid_q && m_ready) begin
                    if (idx_q == CW'(N - 1)) begin
                        state_d   = LOAD;
                        cnt_d     = '0;
                        idx_d     = '0;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        s_ready_d = 1'b1;
                    end else begin
                        idx_d    = idx_nxt_s;
                        m_data_d = res_s[idx_nxt_s];
                        m_last_d = (idx_nxt_s == CW'(N - 1));
                    end
                end else begin
                    state_d = UNLOAD;
                end
            end
            default: begin
                state_d   = LOAD;
                cnt_d     = '0;
                idx_d     = '0;
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            srt_start_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            srt_start_q <= srt_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

`ifdef SORT_TIMEOUT_EN
    // Engine wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign srt_start = srt_start_q;
    assign srt_data  = frame_s;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench for sort_frame_ctrl with a behavioural sort engine
// (done 6 cycles after start). Timeout checks follow SORT_TIMEOUT_EN.
module tb_sort_frame_ctrl;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int TO = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [W-1:0]        s_data = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [W-1:0]        m_data;
    logic                m_last;
    logic                srt_start;
    logic [N-1:0][W-1:0] srt_data;
    logic                srt_done = 1'b0;
    logic [N-1:0][W-1:0] srt_sorted = '0;
    logic                busy;
    logic                err;

    int tests = 0;
    int fails = 0;
    bit engine_en  = 1'b1;
    bit expect_out = 1'b1;
    logic [W-1:0] eng_a [N];
    logic [W-1:0] eng_t;

    sort_frame_ctrl #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .srt_start  (srt_start),
        .srt_data   (srt_data),
        .srt_done   (srt_done),
        .srt_sorted (srt_sorted),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input int gap);
        bit acc;
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            acc = s_ready;
            step();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("send_accept_bound", 64'd0, 64'd1);
        s_valid = 1'b0;
        repeat (gap) step();
    endtask

    // words[k] is the k-th word sent; returns at the sample point right after the last accept
    task automatic send_frame(input logic [N-1:0][W-1:0] words, input logic [N-1:0][3:0] gaps);
        for (int k = 0; k < N; k++) begin
            send(words[k], (k == N - 1) ? 0 : int'(gaps[k]));
        end
    endtask

    task automatic recv_frame(input logic [N-1:0][W-1:0] exp, input bit bp);
        int guard;
        int p;
        logic [3:0] pat;
        pat   = 4'b1001;
        guard = 0;
        p     = 0;
        while (!m_valid && guard < 100) begin
            step();
            guard++;
        end
        check("m_valid_arrive", 64'(m_valid), 64'd1);
        for (int i = 0; i < N; i++) begin
            bit acc;
            int g;
            g = 0;
            do begin
                m_ready = bp ? pat[p % 4] : 1'b1;
                p++;
                check("m_data", 64'(m_data), 64'(exp[i]));
                check("m_last", 64'(m_last), (i == N - 1) ? 64'd1 : 64'd0);
                check("s_ready_in_unload", 64'(s_ready), 64'd0);
                acc = m_ready;
                step();
                g++;
            end while (!acc && g < 10);
        end
        m_ready = 1'b0;
        check("m_valid_after_frame", 64'(m_valid), 64'd0);
        check("busy_after_frame", 64'(busy), 64'd0);
        check("s_ready_after_frame", 64'(s_ready), 64'd1);
    endtask

    // Behavioural sort engine: sort on start, pulse done 6 cycles later.
    always begin
        @(posedge clk);
        #1;
        if (srt_start && engine_en) begin
            for (int k = 0; k < N; k++) eng_a[k] = srt_data[k];
            for (int i = 0; i < N - 1; i++) begin
                for (int j = 0; j < N - 1 - i; j++) begin
                    if (eng_a[j] > eng_a[j + 1]) begin
                        eng_t        = eng_a[j];
                        eng_a[j]     = eng_a[j + 1];
                        eng_a[j + 1] = eng_t;
                    end
                end
            end
            repeat (5) @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) srt_sorted[k] = eng_a[k];
            srt_done = 1'b1;
            @(posedge clk);
            #1;
            srt_done = 1'b0;
            check("first_valid_latency", 64'(m_valid), expect_out ? 64'd1 : 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state
        repeat (3) step();
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_srt_start", 64'(srt_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_srt_data", 64'(srt_data), 64'd0);
        rst = 1'b0;
        step();

        // Frame 1: 5,3,9,1,7,2 with bubbles, backpressured output
        send_frame({8'd2, 8'd7, 8'd1, 8'd9, 8'd3, 8'd5}, {4'd0, 4'd1, 4'd3, 4'd2, 4'd1, 4'd0});
        check("f1_start_after_last", 64'(srt_start), 64'd1);
        check("f1_busy_kick", 64'(busy), 64'd1);
        check("f1_s_ready_kick", 64'(s_ready), 64'd0);
        step();
        check("f1_start_one_cycle", 64'(srt_start), 64'd0);
        check("f1_srt_data_wait", 64'(srt_data), 64'({8'd2, 8'd7, 8'd1, 8'd9, 8'd3, 8'd5}));
        check("f1_busy_wait", 64'(busy), 64'd1);
        check("f1_no_output_wait", 64'(m_valid), 64'd0);
        recv_frame({8'd9, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1}, 1'b1);

        // Frame 2 back-to-back: 200,0,200,17,255,0
        send_frame({8'd0, 8'd255, 8'd17, 8'd200, 8'd0, 8'd200}, '0);
        check("f2_start_after_last", 64'(srt_start), 64'd1);
        step();
        check("f2_start_one_cycle", 64'(srt_start), 64'd0);
        recv_frame({8'd255, 8'd200, 8'd200, 8'd17, 8'd0, 8'd0}, 1'b0);

        // Reset 2 cycles after start; engine done arrives later and must be ignored
        send_frame({8'd5, 8'd6, 8'd1, 8'd2, 8'd3, 8'd4}, '0);
        check("rw_start", 64'(srt_start), 64'd1);
        expect_out = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rw_s_ready_after_rst", 64'(s_ready), 64'd1);
        check("rw_busy_after_rst", 64'(busy), 64'd0);
        step();
        check("rw_s_ready_held", 64'(s_ready), 64'd1);
        repeat (7) step();
        check("rw_no_m_valid", 64'(m_valid), 64'd0);
        check("rw_still_load", 64'(busy), 64'd0);
        expect_out = 1'b1;

        // Frame after reset: 40,10,30,20,60,50
        send_frame({8'd50, 8'd60, 8'd20, 8'd30, 8'd10, 8'd40}, {4'd0, 4'd0, 4'd2, 4'd0, 4'd1, 4'd0});
        step();
        check("f3_srt_data_wait", 64'(srt_data), 64'({8'd50, 8'd60, 8'd20, 8'd30, 8'd10, 8'd40}));
        recv_frame({8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 1'b1);

        // Engine never answers
        engine_en = 1'b0;
        send_frame({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, '0);
`ifdef SORT_TIMEOUT_EN
        k = 0;
        while (!err && k < 100) begin
            step();
            k++;
        end
        // KICK cycle, then 16 WAIT cycles, err on the next one
        check("to_err_cycle", 64'(k), 64'(TO + 1));
        check("to_busy", 64'(busy), 64'd0);
        check("to_s_ready", 64'(s_ready), 64'd1);
        check("to_no_output", 64'(m_valid), 64'd0);
        step();
        check("to_err_one_cycle", 64'(err), 64'd0);
        engine_en = 1'b1;
        send_frame({8'd3, 8'd9, 8'd8, 8'd7, 8'd4, 8'd1}, '0);
        recv_frame({8'd9, 8'd8, 8'd7, 8'd4, 8'd3, 8'd1}, 1'b0);
`else
        k = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (err) k++;
        end
        check("nto_err_never", 64'(k), 64'd0);
        check("nto_busy_held", 64'(busy), 64'd1);
        check("nto_no_output", 64'(m_valid), 64'd0);
        check("nto_s_ready_low", 64'(s_ready), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
